// File: rtl/isr_seq_pkg.sv
// Shared constants for the exception entry/return sequencer: control-register
// ids, SR bit positions and the sequencer state encoding.
package isr_seq_pkg;

  localparam logic [6:0] JX2_CR_SR   = 7'h40;
  localparam logic [6:0] JX2_CR_SPC  = 7'h41;
  localparam logic [6:0] JX2_CR_SSP  = 7'h42;
  localparam logic [6:0] JX2_CR_EXSR = 7'h4E;
  localparam logic [6:0] JX2_CR_TEA  = 7'h4F;
  localparam logic [6:0] JX2_CR_ZZR  = 7'h7F;

  localparam int SR_ISR_BIT = 28;
  localparam int SR_MD_BIT  = 30;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_E_EXSR = 4'd1,
    ST_E_TEA  = 4'd2,
    ST_E_SPC  = 4'd3,
    ST_E_SSP  = 4'd4,
    ST_E_SR   = 4'd5,
    ST_E_BR   = 4'd6,
    ST_R_SR   = 4'd7,
    ST_R_BR   = 4'd8
  } isr_state_e;

endpackage

// File: rtl/isr_vec_calc.sv
// Trap vector computation: VBR + (class << VEC_SHIFT), with the class forced
// to 0 when a trap is taken while SR.ISR is already set.
module isr_vec_calc
  import isr_seq_pkg::*;
#(
  parameter int VEC_SHIFT  = 3,
  parameter bit ENABLE_DBL = 1'b1
) (
  input  logic [47:0] i_vbr,
  input  logic [3:0]  i_cls,
  input  logic        i_isr,
  output logic [47:0] o_vec,
  output logic        o_dbl
);

  logic [47:0] w_cls;

  assign o_dbl = ENABLE_DBL && i_isr;
  assign w_cls = o_dbl ? 48'd0 : {44'd0, i_cls};
  // The add is deliberately 48 bits wide so the vector wraps mod 2^48.
  assign o_vec = i_vbr + (w_cls << VEC_SHIFT);

endmodule

// File: rtl/isr_seq.sv
// Exception entry/return sequencer: owns the CR write port while busy and
// writes EXSR, TEA, SPC, SSP, SR one per cycle, then redirects the PC.
module isr_seq
  import isr_seq_pkg::*;
#(
  parameter int vecShift       = 3,
  parameter bit enableDblFault = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        trapReq,
  input  logic [15:0] trapCode,
  input  logic [63:0] trapTea,
  input  logic        rteReq,
  input  logic [63:0] regInSr,
  input  logic [63:0] regInExsr,
  input  logic [47:0] regInSpc,
  input  logic [47:0] regInVbr,
  input  logic [47:0] curPc,
  input  logic [47:0] curSp,
  output logic [6:0]  crWrId,
  output logic [63:0] crWrVal,
  output logic        redirValid,
  output logic [47:0] redirPc,
  output logic        flushReq,
  output logic        trapAck,
  output logic        rteAck,
  output logic        busy,
  output logic        dblFault
);

  isr_state_e  r_state, w_state_nxt;
  logic [3:0]  r_cls;
  logic [63:0] r_tea, r_sr;
  logic [47:0] r_pc, r_sp, r_vbr;

  logic [6:0]  r_cr_wr_id, w_cr_wr_id;
  logic [63:0] r_cr_wr_val, w_cr_wr_val;
  logic        r_redir_valid, w_redir_valid;
  logic [47:0] r_redir_pc, w_redir_pc;
  logic        r_trap_ack, w_trap_ack;
  logic        r_rte_ack, w_rte_ack;
  logic        r_busy, r_dbl_fault, w_dbl_fault;

  logic [47:0] w_vec;
  logic        w_dbl_hit;
  logic        w_unused;

  assign w_unused = ^regInExsr[31:0];

  isr_vec_calc #(
    .VEC_SHIFT  (vecShift),
    .ENABLE_DBL (enableDblFault)
  ) u_vec_calc (
    .i_vbr (r_vbr),
    .i_cls (r_cls),
    .i_isr (r_sr[SR_ISR_BIT]),
    .o_vec (w_vec),
    .o_dbl (w_dbl_hit)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (trapReq)     w_state_nxt = ST_E_EXSR;
        else if (rteReq) w_state_nxt = ST_R_SR;
      end
      ST_E_EXSR: w_state_nxt = ST_E_TEA;
      ST_E_TEA:  w_state_nxt = ST_E_SPC;
      ST_E_SPC:  w_state_nxt = ST_E_SSP;
      ST_E_SSP:  w_state_nxt = ST_E_SR;
      ST_E_SR:   w_state_nxt = ST_E_BR;
      ST_R_SR:   w_state_nxt = ST_R_BR;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and then registered.
  // E_EXSR and R_SR are only entered from IDLE, so they read the live inputs.
  always_comb begin
    w_cr_wr_id    = JX2_CR_ZZR;
    w_cr_wr_val   = 64'd0;
    w_redir_valid = 1'b0;
    w_redir_pc    = r_redir_pc;
    w_trap_ack    = 1'b0;
    w_rte_ack     = 1'b0;
    w_dbl_fault   = r_dbl_fault;
    unique case (w_state_nxt)
      ST_E_EXSR: begin
        w_cr_wr_id  = JX2_CR_EXSR;
        w_cr_wr_val = {regInSr[31:0], 16'h0, trapCode};
      end
      ST_E_TEA: begin
        w_cr_wr_id  = JX2_CR_TEA;
        w_cr_wr_val = r_tea;
      end
      ST_E_SPC: begin
        w_cr_wr_id  = JX2_CR_SPC;
        w_cr_wr_val = {16'h0, r_pc};
      end
      ST_E_SSP: begin
        w_cr_wr_id  = JX2_CR_SSP;
        w_cr_wr_val = {16'h0, r_sp};
      end
      ST_E_SR: begin
        w_cr_wr_id  = JX2_CR_SR;
        w_cr_wr_val = r_sr | (64'd1 << SR_ISR_BIT) | (64'd1 << SR_MD_BIT);
      end
      ST_E_BR: begin
        w_redir_valid = 1'b1;
        w_redir_pc    = w_vec;
        w_trap_ack    = 1'b1;
        if (w_dbl_hit) w_dbl_fault = 1'b1;
      end
      ST_R_SR: begin
        w_cr_wr_id  = JX2_CR_SR;
        w_cr_wr_val = {regInSr[63:32], regInExsr[63:32]};
        w_dbl_fault = 1'b0;
      end
      ST_R_BR: begin
        w_redir_valid = 1'b1;
        w_redir_pc    = regInSpc;
        w_rte_ack     = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cls         <= 4'd0;
      r_tea         <= 64'd0;
      r_sr          <= 64'd0;
      r_pc          <= 48'd0;
      r_sp          <= 48'd0;
      r_vbr         <= 48'd0;
      r_cr_wr_id    <= JX2_CR_ZZR;
      r_cr_wr_val   <= 64'd0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 48'd0;
      r_trap_ack    <= 1'b0;
      r_rte_ack     <= 1'b0;
      r_busy        <= 1'b0;
      r_dbl_fault   <= 1'b0;
    end else if (!hold) begin
      r_state       <= w_state_nxt;
      r_cr_wr_id    <= w_cr_wr_id;
      r_cr_wr_val   <= w_cr_wr_val;
      r_redir_valid <= w_redir_valid;
      r_redir_pc    <= w_redir_pc;
      r_trap_ack    <= w_trap_ack;
      r_rte_ack     <= w_rte_ack;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_dbl_fault   <= w_dbl_fault;
      if (r_state == ST_IDLE && trapReq) begin
        r_cls <= trapCode[15:12];
        r_tea <= trapTea;
        r_sr  <= regInSr;
        r_pc  <= curPc;
        r_sp  <= curSp;
        r_vbr <= regInVbr;
      end
    end
  end

  assign crWrId   = r_cr_wr_id;
  assign crWrVal  = r_cr_wr_val;
  assign redirPc  = r_redir_pc;
  assign busy     = r_busy;
  // Younger stages must be flushed for exactly the span the port is owned.
  assign flushReq = r_busy;
  assign dblFault = r_dbl_fault;
  // A stalled redirect/ack is masked and re-presented once hold drops.
  assign redirValid = r_redir_valid & ~hold;
  assign trapAck    = r_trap_ack & ~hold;
  assign rteAck     = r_rte_ack & ~hold;

endmodule

// File: tb/tb_isr_seq.sv
// Scoreboard bench for isr_seq: each request pushes its expected CR writes and
// redirects (with cycle stamps); a negedge monitor pops and compares them.
module tb_isr_seq;
  import isr_seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        trapReq = 1'b0;
  logic [15:0] trapCode = '0;
  logic [63:0] trapTea = '0;
  logic        rteReq = 1'b0;
  logic [63:0] regInSr = '0;
  logic [63:0] regInExsr = '0;
  logic [47:0] regInSpc = '0;
  logic [47:0] regInVbr = '0;
  logic [47:0] curPc = '0;
  logic [47:0] curSp = '0;
  logic [6:0]  crWrId;
  logic [63:0] crWrVal;
  logic        redirValid;
  logic [47:0] redirPc;
  logic        flushReq, trapAck, rteAck, busy, dblFault;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [6:0]  id;
    logic [63:0] val;
    logic        redir;
    logic [47:0] pc;
    logic        tack;
    logic        rack;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;

  isr_seq dut (
    .clock(clock), .reset(reset), .hold(hold),
    .trapReq(trapReq), .trapCode(trapCode), .trapTea(trapTea),
    .rteReq(rteReq), .regInSr(regInSr), .regInExsr(regInExsr),
    .regInSpc(regInSpc), .regInVbr(regInVbr), .curPc(curPc), .curSp(curSp),
    .crWrId(crWrId), .crWrVal(crWrVal), .redirValid(redirValid),
    .redirPc(redirPc), .flushReq(flushReq), .trapAck(trapAck),
    .rteAck(rteAck), .busy(busy), .dblFault(dblFault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset && (crWrId != JX2_CR_ZZR || redirValid || trapAck || rteAck)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        m_e = sb_q.pop_front();
        check("cycle", 64'(cyc), 64'(m_e.cyc));
        check("cr_id", {57'd0, crWrId}, {57'd0, m_e.id});
        check("cr_val", crWrVal, m_e.val);
        check("redir_valid", {63'd0, redirValid}, {63'd0, m_e.redir});
        if (m_e.redir) check("redir_pc", {16'd0, redirPc}, {16'd0, m_e.pc});
        check("trap_ack", {63'd0, trapAck}, {63'd0, m_e.tack});
        check("rte_ack", {63'd0, rteAck}, {63'd0, m_e.rack});
      end
    end
  end

  function automatic logic [47:0] model_vec(logic [47:0] vbr, logic [15:0] code, logic [63:0] sr);
    logic [47:0] cls;
    cls = sr[28] ? 48'd0 : {44'd0, code[15:12]};
    return vbr + (cls << 3);
  endfunction

  task automatic push_trap(input int c0, input logic [15:0] code, input logic [63:0] tea,
                           input logic [47:0] pc, input logic [47:0] sp, input logic [63:0] sr,
                           input logic [47:0] vbr, input int hold_step, input int hold_len,
                           input int nsteps, output int ack_cyc);
    exp_t e;
    int hadd = 0;
    for (int k = 0; k < nsteps; k++) begin
      int reps;
      reps = (k == hold_step) ? hold_len + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        e.cyc = c0 + 1 + k + hadd + r;
        e.redir = (k == 5); e.tack = (k == 5); e.rack = 1'b0;
        e.pc = (k == 5) ? model_vec(vbr, code, sr) : 48'd0;
        case (k)
          0: begin e.id = JX2_CR_EXSR; e.val = {sr[31:0], 16'h0, code}; end
          1: begin e.id = JX2_CR_TEA;  e.val = tea; end
          2: begin e.id = JX2_CR_SPC;  e.val = {16'h0, pc}; end
          3: begin e.id = JX2_CR_SSP;  e.val = {16'h0, sp}; end
          4: begin e.id = JX2_CR_SR;   e.val = sr | 64'h5000_0000; end
          default: begin e.id = JX2_CR_ZZR; e.val = 64'd0; end
        endcase
        sb_q.push_back(e);
      end
      if (k == hold_step) hadd += hold_len;
    end
    ack_cyc = c0 + 6 + hadd;
  endtask

  task automatic push_rte(input int c_sr, input logic [63:0] exsr, input logic [63:0] sr,
                          input logic [47:0] spc);
    exp_t e;
    e = '{cyc: c_sr, id: JX2_CR_SR, val: {sr[63:32], exsr[63:32]}, redir: 1'b0,
          pc: 48'd0, tack: 1'b0, rack: 1'b0};
    sb_q.push_back(e);
    e = '{cyc: c_sr + 1, id: JX2_CR_ZZR, val: 64'd0, redir: 1'b1,
          pc: spc, tack: 1'b0, rack: 1'b1};
    sb_q.push_back(e);
  endtask

  task automatic drive_trap(input logic [15:0] code, input logic [63:0] tea, input logic [47:0] pc,
                            input logic [47:0] sp, input logic [63:0] sr, input logic [47:0] vbr);
    trapCode = code; trapTea = tea; curPc = pc; curSp = sp; regInSr = sr; regInVbr = vbr;
    trapReq = 1'b1;
  endtask

  task automatic run_trap(input logic [15:0] code, input logic [63:0] tea, input logic [47:0] pc,
                          input logic [47:0] sp, input logic [63:0] sr, input logic [47:0] vbr,
                          input int hold_step, input int hold_len, input logic exp_dbl);
    int c0, ack;
    @(negedge clock); #1;
    drive_trap(code, tea, pc, sp, sr, vbr);
    c0 = cyc;
    push_trap(c0, code, tea, pc, sp, sr, vbr, hold_step, hold_len, 6, ack);
    while (cyc < ack) begin
      @(negedge clock); #1;
      if (hold_step >= 0 && cyc == c0 + 1 + hold_step) hold = 1'b1;
      if (hold_step >= 0 && cyc == c0 + 1 + hold_step + hold_len) hold = 1'b0;
    end
    trapReq = 1'b0;
    check("dbl_fault_at_ack", {63'd0, dblFault}, {63'd0, exp_dbl});
  endtask

  task automatic run_rte(input logic [63:0] exsr, input logic [63:0] sr, input logic [47:0] spc);
    int c0;
    @(negedge clock); #1;
    regInExsr = exsr; regInSr = sr; regInSpc = spc; rteReq = 1'b1;
    c0 = cyc;
    push_rte(c0 + 1, exsr, sr, spc);
    while (cyc < c0 + 2) begin @(negedge clock); #1; end
    rteReq = 1'b0;
    check("dbl_fault_after_rte", {63'd0, dblFault}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cr_id"}, {57'd0, crWrId}, {57'd0, JX2_CR_ZZR});
    check({pfx, "_cr_val"}, crWrVal, 64'd0);
    check({pfx, "_redir_pc"}, {16'd0, redirPc}, 64'd0);
    check({pfx, "_strobes"},
          {58'd0, redirValid, flushReq, trapAck, rteAck, busy, dblFault}, 64'd0);
  endtask

  initial begin
    int c0, ack;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    #1 reset = 1'b1;

    // Basic entry: class 0xA, VBR 0x10000 -> 0x10050.
    run_trap(16'hA003, 64'h1234, 48'h4000, 48'h8000, 64'h0, 48'h10000, -1, 0, 1'b0);
    // Same trap stalled for two cycles in E_SPC.
    run_trap(16'hA003, 64'h1234, 48'h4000, 48'h8000, 64'h0, 48'h10000, 2, 2, 1'b0);
    // Double fault: SR.ISR already set, class 5 forced to 0.
    run_trap(16'h5001, 64'hDEAD_BEEF, 48'h4100, 48'h8100, 64'h1000_0000, 48'h20000, -1, 0, 1'b1);
    // Return: SR restored from EXSR high word, dblFault cleared.
    run_rte(64'h0000_0003_0000_0000, 64'hFFFF_FFFF_5000_0000, 48'h4000);

    // Trap and RTE together: trap first (vector wraps mod 2^48), then RTE.
    @(negedge clock); #1;
    drive_trap(16'hF0FF, 64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFE, 48'h1, 64'h0, 48'hFFFF_FFFF_FFC0);
    regInExsr = 64'h8765_4321_0000_0000; regInSpc = 48'h1234_5678_9ABC; rteReq = 1'b1;
    c0 = cyc;
    push_trap(c0, 16'hF0FF, 64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFE, 48'h1, 64'h0,
              48'hFFFF_FFFF_FFC0, -1, 0, 6, ack);
    push_rte(ack + 2, 64'h8765_4321_0000_0000, 64'hAAAA_5555_0000_0000, 48'h1234_5678_9ABC);
    while (cyc < ack) begin @(negedge clock); #1; end
    trapReq = 1'b0;
    regInSr = 64'hAAAA_5555_0000_0000;
    while (cyc < ack + 3) begin @(negedge clock); #1; end
    rteReq = 1'b0;

    // Set dblFault, then abandon a second trap with reset in E_SSP.
    run_trap(16'h3000, 64'h0, 48'h100, 48'h200, 64'h1000_0000, 48'h3000, -1, 0, 1'b1);
    @(negedge clock); #1;
    drive_trap(16'h2222, 64'h55, 48'h600, 48'h700, 64'h0, 48'h5000);
    c0 = cyc;
    push_trap(c0, 16'h2222, 64'h55, 48'h600, 48'h700, 64'h0, 48'h5000, -1, 0, 4, ack);
    while (cyc < c0 + 4) begin @(negedge clock); #1; end
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    trapReq = 1'b0;
    @(negedge clock); #1;
    check_reset_outputs("held_reset");
    reset = 1'b1;
    run_trap(16'h2222, 64'h55, 48'h600, 48'h700, 64'h0, 48'h5000, -1, 0, 1'b0);

    repeat (3) @(negedge clock);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
